// File: rtl/lab3_mem_line_mem_responder_pkg.sv
// Shared memory message types and type codes for the 16-byte line responder.
package lab3_mem_line_mem_responder_pkg;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
    localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

    typedef struct packed {
        logic [2:0]   type_;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   type_;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    // WRITE and INIT both modify the line array; every other type leaves it alone.
    function automatic logic is_write_type(input logic [2:0] t);
        return (t == MEM_TYPE_WRITE) || (t == MEM_TYPE_INIT);
    endfunction

endpackage

// File: rtl/lab3_mem_line_mem_responder_wben_gen.sv
// Turns a byte offset and length into a 16-bit byte enable and lane-shifted write data.
module lab3_mem_WbenGen (
    input  logic [3:0]   offset,
    input  logic [3:0]   len,
    input  logic [127:0] data,
    output logic [15:0]  wben,
    output logic [127:0] wdata
);

    logic [4:0] last;
    logic [4:0] pos;
    logic [3:0] lane;

    // len of zero means a full line; otherwise bytes run from offset and anything past byte 15 is dropped.
    always_comb begin
        wben  = '0;
        wdata = '0;
        pos   = '0;
        lane  = '0;
        last  = {1'b0, offset} + {1'b0, len};
        if (len == 4'd0) begin
            wben  = '1;
            wdata = data;
        end else begin
            for (int i = 0; i < 16; i++) begin
                pos = 5'(i);
                if ((pos >= {1'b0, offset}) && (pos < last)) begin
                    lane             = 4'(i) - offset;
                    wben[i]          = 1'b1;
                    wdata[i*8 +: 8]  = data[{lane, 3'b000} +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/lab3_mem_line_mem_responder.sv
// Blocking single-ported line memory: accept one request, touch the array, wait p_latency, respond.
import lab3_mem_line_mem_responder_pkg::*;

module lab3_mem_line_mem_responder #(
    parameter int p_num_lines = 64,
    parameter int p_latency   = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memreq_val,
    output logic          memreq_rdy,
    input  mem_req_16B_t  memreq_msg,
    output logic          memresp_val,
    input  logic          memresp_rdy,
    output mem_resp_16B_t memresp_msg
);

    localparam int idw = $clog2(p_num_lines);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        state;
    state_t        state_next;
    mem_req_16B_t  req_reg;
    logic [127:0]  resp_data;
    logic [7:0]    count;
    logic          req_fire;
    logic          resp_fire;
    logic          do_write;
    logic [idw-1:0] idx;
    logic [15:0]   wben;
    logic [127:0]  wdata;
    logic          unused_addr_bits;

    logic [127:0]  line_mem [p_num_lines];

    assign idx              = req_reg.addr[4+idw-1:4];
    assign unused_addr_bits = ^{req_reg.addr[31:4+idw]};

    assign memreq_rdy  = (state == ST_IDLE) && !reset;
    assign memresp_val = (state == ST_RESP) && !reset;
    assign req_fire    = memreq_val && memreq_rdy;
    assign resp_fire   = memresp_val && memresp_rdy;
    assign do_write    = (state == ST_ACCESS) && is_write_type(req_reg.type_);

    assign memresp_msg.type_  = req_reg.type_;
    assign memresp_msg.opaque = req_reg.opaque;
    assign memresp_msg.test   = 2'd0;
    assign memresp_msg.len    = 4'd0;
    assign memresp_msg.data   = resp_data;

    lab3_mem_WbenGen wben_gen (
        .offset (req_reg.addr[3:0]),
        .len    (req_reg.len),
        .data   (req_reg.data),
        .wben   (wben),
        .wdata  (wdata)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic: ACCESS is always a single cycle, WAIT is skipped entirely when p_latency is zero.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (req_fire) state_next = ST_ACCESS;
            ST_ACCESS: state_next = (p_latency > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT:   if (count <= 8'd1) state_next = ST_RESP;
            ST_RESP:   if (resp_fire) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Request register holds the whole message for the duration of the transaction.
    always_ff @(posedge clk) begin
        if (reset)         req_reg <= '0;
        else if (req_fire) req_reg <= memreq_msg;
    end

    // Latency counter is loaded in ACCESS and counts down through WAIT.
    always_ff @(posedge clk) begin
        if (reset)                   count <= '0;
        else if (state == ST_ACCESS) count <= 8'(p_latency);
        else if (state == ST_WAIT)   count <= count - 8'd1;
    end

    // Response data is captured once in ACCESS so it stays stable while the response stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_data <= '0;
        end else if (state == ST_ACCESS) begin
            if (req_reg.type_ == MEM_TYPE_READ) resp_data <= line_mem[idx];
            else                                resp_data <= '0;
        end
    end

    // Line array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 16; b++) begin
                if (wben[b]) line_mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// Directed self-checking bench: three responders with latency 0, 3 and 5 share clock and reset.
module tb_lab3_mem_line_mem_responder;
    import lab3_mem_line_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic          req_val  [3];
    logic          req_rdy  [3];
    logic          resp_val [3];
    logic          resp_rdy [3];
    mem_req_16B_t  req_msg  [3];
    mem_resp_16B_t resp_msg [3];

    lab3_mem_line_mem_responder #(.p_num_lines(64), .p_latency(0)) dut_lat0 (
        .clk(clk), .reset(reset),
        .memreq_val(req_val[0]), .memreq_rdy(req_rdy[0]), .memreq_msg(req_msg[0]),
        .memresp_val(resp_val[0]), .memresp_rdy(resp_rdy[0]), .memresp_msg(resp_msg[0]));

    lab3_mem_line_mem_responder #(.p_num_lines(64), .p_latency(3)) dut_lat3 (
        .clk(clk), .reset(reset),
        .memreq_val(req_val[1]), .memreq_rdy(req_rdy[1]), .memreq_msg(req_msg[1]),
        .memresp_val(resp_val[1]), .memresp_rdy(resp_rdy[1]), .memresp_msg(resp_msg[1]));

    lab3_mem_line_mem_responder #(.p_num_lines(64), .p_latency(5)) dut_lat5 (
        .clk(clk), .reset(reset),
        .memreq_val(req_val[2]), .memreq_rdy(req_rdy[2]), .memreq_msg(req_msg[2]),
        .memresp_val(resp_val[2]), .memresp_rdy(resp_rdy[2]), .memresp_msg(resp_msg[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic mem_resp_16B_t mk_resp(input logic [2:0] t, input logic [7:0] op, input logic [127:0] d);
        mem_resp_16B_t r;
        r.type_ = t; r.opaque = op; r.test = 2'd0; r.len = 4'd0; r.data = d;
        return r;
    endfunction

    // Full transaction with memresp_rdy held high; hs is the handshake cycle, lat the cycles until memresp_val.
    task automatic txn(input int k, input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                       input logic [3:0] l, input logic [127:0] d,
                       output mem_resp_16B_t r, output int hs, output int lat, output logic ok);
        int n;
        @(negedge clk);
        resp_rdy[k] = 1'b1;
        req_val[k]  = 1'b1;
        req_msg[k]  = '{type_: t, opaque: op, addr: a, len: l, data: d};
        hs = cyc;
        @(posedge clk); #1;
        req_val[k] = 1'b0;
        n = 0;
        while (resp_val[k] !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        ok  = (resp_val[k] === 1'b1);
        lat = cyc - hs;
        r   = resp_msg[k];
        if (ok) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_rdy[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdy_during dut%0d got %b exp 0", k, req_rdy[k]); end
        end
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_rdy[k] !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdy_after dut%0d got %b exp 1", k, req_rdy[k]); end
            checks++;
            if (resp_val[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_val dut%0d got %b exp 0", k, resp_val[k]); end
            checks++;
            if (resp_msg[k] !== '0) begin errors++; $display("[TB] FAIL reset_msg dut%0d got %h exp 0", k, resp_msg[k]); end
        end
    endtask

    task automatic test_write_read();
        mem_resp_16B_t r, e;
        int hs, lat;
        logic ok;
        txn(0, MEM_TYPE_WRITE, 8'h11, 32'h0000_1000, 4'd0, 128'h0F0E0D0C0B0A09080706050403020100, r, hs, lat, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL wr_timeout got no memresp_val exp response"); end
        checks++;
        if (lat !== 2) begin errors++; $display("[TB] FAIL wr_latency got %0d exp 2", lat); end
        e = mk_resp(3'd1, 8'h11, '0);
        checks++;
        if (r !== e) begin errors++; $display("[TB] FAIL wr_resp got %h exp %h", r, e); end
        txn(0, MEM_TYPE_READ, 8'h22, 32'h0000_1000, 4'd0, '0, r, hs, lat, ok);
        e = mk_resp(3'd0, 8'h22, 128'h0F0E0D0C0B0A09080706050403020100);
        checks++;
        if (!ok || r !== e) begin errors++; $display("[TB] FAIL rd_resp got %h exp %h", r, e); end
    endtask

    task automatic test_partial_write();
        mem_resp_16B_t r, e;
        int hs, lat;
        logic ok;
        txn(0, MEM_TYPE_WRITE, 8'h01, 32'h0000_1000, 4'd0, {16{8'hFF}}, r, hs, lat, ok);
        txn(0, MEM_TYPE_WRITE, 8'h02, 32'h0000_1006, 4'd4, 128'h99887766_55443322_11000000_DDCCBBAA, r, hs, lat, ok);
        txn(0, MEM_TYPE_READ, 8'h03, 32'h0000_1000, 4'd0, '0, r, hs, lat, ok);
        e = mk_resp(3'd0, 8'h03, 128'hFFFFFFFFFFFFDDCCBBAAFFFFFFFFFFFF);
        checks++;
        if (!ok || r !== e) begin errors++; $display("[TB] FAIL partial_write got %h exp %h", r, e); end
    endtask

    task automatic test_offset_overflow();
        mem_resp_16B_t r, e;
        int hs, lat;
        logic ok;
        txn(0, MEM_TYPE_WRITE, 8'h04, 32'h0000_1010, 4'd0, {16{8'h5A}}, r, hs, lat, ok);
        txn(0, MEM_TYPE_WRITE, 8'h05, 32'h0000_100E, 4'd4, 128'h44332211, r, hs, lat, ok);
        txn(0, MEM_TYPE_READ, 8'h06, 32'h0000_1000, 4'd0, '0, r, hs, lat, ok);
        e = mk_resp(3'd0, 8'h06, 128'h2211FFFFFFFFDDCCBBAAFFFFFFFFFFFF);
        checks++;
        if (!ok || r !== e) begin errors++; $display("[TB] FAIL overflow_line got %h exp %h", r, e); end
        txn(0, MEM_TYPE_READ, 8'h07, 32'h0000_1010, 4'd0, '0, r, hs, lat, ok);
        e = mk_resp(3'd0, 8'h07, {16{8'h5A}});
        checks++;
        if (!ok || r !== e) begin errors++; $display("[TB] FAIL overflow_next_line got %h exp %h", r, e); end
    endtask

    task automatic test_init_and_other_type();
        mem_resp_16B_t r, e;
        int hs, lat;
        logic ok;
        txn(0, MEM_TYPE_INIT, 8'h31, 32'h0000_1020, 4'd0, 128'h0123456789ABCDEF_FEDCBA9876543210, r, hs, lat, ok);
        e = mk_resp(3'd2, 8'h31, '0);
        checks++;
        if (!ok || r !== e) begin errors++; $display("[TB] FAIL init_resp got %h exp %h", r, e); end
        txn(0, 3'd3, 8'h32, 32'h0000_1020, 4'd0, {16{8'hEE}}, r, hs, lat, ok);
        e = mk_resp(3'd3, 8'h32, '0);
        checks++;
        if (!ok || r !== e) begin errors++; $display("[TB] FAIL other_type_resp got %h exp %h", r, e); end
        txn(0, MEM_TYPE_READ, 8'h33, 32'h0000_1020, 4'd0, '0, r, hs, lat, ok);
        e = mk_resp(3'd0, 8'h33, 128'h0123456789ABCDEF_FEDCBA9876543210);
        checks++;
        if (!ok || r !== e) begin errors++; $display("[TB] FAIL init_readback got %h exp %h", r, e); end
    endtask

    task automatic test_alias();
        mem_resp_16B_t r, e;
        int hs, lat;
        logic ok;
        txn(0, MEM_TYPE_WRITE, 8'h41, 32'h0000_0010, 4'd0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, r, hs, lat, ok);
        txn(0, MEM_TYPE_READ, 8'h42, 32'h0000_0410, 4'd0, '0, r, hs, lat, ok);
        e = mk_resp(3'd0, 8'h42, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        checks++;
        if (!ok || r !== e) begin errors++; $display("[TB] FAIL alias_read got %h exp %h", r, e); end
    endtask

    task automatic test_latency_stall();
        mem_resp_16B_t r, e, held;
        int hs, lat, n;
        logic ok;
        txn(1, MEM_TYPE_WRITE, 8'h51, 32'h0000_2000, 4'd0, 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF, r, hs, lat, ok);
        checks++;
        if (!ok || lat !== 5) begin errors++; $display("[TB] FAIL lat3_latency got %0d exp 5", lat); end
        @(negedge clk);
        resp_rdy[1] = 1'b0;
        req_val[1]  = 1'b1;
        req_msg[1]  = '{type_: MEM_TYPE_READ, opaque: 8'h52, addr: 32'h0000_2000, len: 4'd0, data: '0};
        hs = cyc;
        @(posedge clk); #1;
        req_msg[1] = '{type_: MEM_TYPE_WRITE, opaque: 8'h53, addr: 32'h0000_2000, len: 4'd0, data: {16{8'h77}}};
        n = 0;
        while (resp_val[1] !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
        checks++;
        if (resp_val[1] !== 1'b1 || cyc - hs !== 5) begin errors++; $display("[TB] FAIL stall_val_cycle got %0d exp 5", cyc - hs); end
        held = resp_msg[1];
        e = mk_resp(3'd0, 8'h52, 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF);
        checks++;
        if (held !== e) begin errors++; $display("[TB] FAIL stall_msg got %h exp %h", held, e); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_val[1] !== 1'b1 || resp_msg[1] !== e || req_rdy[1] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d got val=%b rdy=%b msg=%h exp val=1 rdy=0 msg=%h", i, resp_val[1], req_rdy[1], resp_msg[1], e);
            end
        end
        @(negedge clk);
        req_val[1]  = 1'b0;
        resp_rdy[1] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_val[1] !== 1'b0 || req_rdy[1] !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_fire got val=%b rdy=%b exp val=0 rdy=1", resp_val[1], req_rdy[1]);
        end
        txn(1, MEM_TYPE_READ, 8'h54, 32'h0000_2000, 4'd0, '0, r, hs, lat, ok);
        e = mk_resp(3'd0, 8'h54, 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF);
        checks++;
        if (!ok || r !== e) begin errors++; $display("[TB] FAIL stall_ignored_req got %h exp %h", r, e); end
    endtask

    task automatic test_back_to_back();
        mem_resp_16B_t r;
        int hs1, hs2, lat;
        logic ok;
        txn(1, MEM_TYPE_READ, 8'h61, 32'h0000_2000, 4'd0, '0, r, hs1, lat, ok);
        txn(1, MEM_TYPE_READ, 8'h62, 32'h0000_2000, 4'd0, '0, r, hs2, lat, ok);
        checks++;
        if (!ok || hs2 - hs1 !== 6) begin errors++; $display("[TB] FAIL b2b_interval got %0d exp 6", hs2 - hs1); end
        checks++;
        if (r.opaque !== 8'h62) begin errors++; $display("[TB] FAIL b2b_opaque got %h exp 62", r.opaque); end
    endtask

    task automatic test_reset_mid_wait();
        mem_resp_16B_t r, e;
        int hs, lat, seen;
        logic ok;
        @(negedge clk);
        resp_rdy[2] = 1'b1;
        req_val[2]  = 1'b1;
        req_msg[2]  = '{type_: MEM_TYPE_WRITE, opaque: 8'h71, addr: 32'h0000_3000, len: 4'd0, data: 128'hC3C3C3C3_12121212_3C3C3C3C_45454545};
        @(posedge clk); #1;
        req_val[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (req_rdy[2] !== 1'b0 || resp_val[2] !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_during got rdy=%b val=%b exp rdy=0 val=0", req_rdy[2], resp_val[2]);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (req_rdy[2] !== 1'b1) begin errors++; $display("[TB] FAIL midreset_rdy_after got %b exp 1", req_rdy[2]); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resp_val[2] === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("[TB] FAIL midreset_no_resp got %0d valid cycles exp 0", seen); end
        txn(2, MEM_TYPE_READ, 8'h72, 32'h0000_3000, 4'd0, '0, r, hs, lat, ok);
        e = mk_resp(3'd0, 8'h72, 128'hC3C3C3C3_12121212_3C3C3C3C_45454545);
        checks++;
        if (!ok || r !== e) begin errors++; $display("[TB] FAIL midreset_committed got %h exp %h", r, e); end
        checks++;
        if (lat !== 7) begin errors++; $display("[TB] FAIL lat5_latency got %0d exp 7", lat); end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            req_val[k]  = 1'b0;
            resp_rdy[k] = 1'b1;
            req_msg[k]  = '0;
        end
        $display("[TB] starting line memory responder bench");
        @(posedge clk);
        @(posedge clk);
        test_reset();
        test_write_read();
        test_partial_write();
        test_offset_overflow();
        test_init_and_other_type();
        test_alias();
        test_latency_stall();
        test_back_to_back();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
